ascon_permutation_engine: RTL and testbench

- Iterative Ascon permutation p^R over the 320-bit state_t (five 64-bit words).
- Each round applies: round-constant addition on x2, 5-bit S-box layer, then linear diffusion.
- Round count is chosen per request (p^12/p^8/p^6 and any R in 1..12); UNROLL rounds are computed per clock.
- Sits between the Ascon mode controller (AEAD/hash sequencing) and the state register file, using valid/ready on both sides.

---
 rtl/ascon_permutation_engine.sv | 166 ++++++++++++++++
 tb/tb_ascon_permutation_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_engine.sv
// Ascon permutation p^R, UNROLL rounds per clock, valid/ready on both sides.
// Ports: clk_i/rst_ni (sync, active-low); in_valid_i/in_ready_o, rounds_i,
// state_i (request); out_valid_o/out_ready_i, state_o, err_o (result);
// abort_i drops the current request; busy_o is high in RUN or DONE.
package ascon_pkg;
    typedef logic [319:0] state_t;
endpackage

module ascon_permutation_engine
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [3:0] rounds_i,
    input  state_t     state_i,
    input  logic       abort_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output state_t     state_o,
    output logic       busy_o,
    output logic       err_o
);

    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("UNROLL must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t       r_fsm;
    fsm_t       w_fsm_nxt;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_rounds;
    logic       r_err;

    function automatic logic [63:0] ror64(logic [63:0] v, int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic state_t ascon_round(state_t s, logic [7:0] rc);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, rc};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 ^= x4;
        x4 ^= x3;
        x2 ^= x1;
        // chi step: all temporaries from the pre-update words
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 ^= t1;
        x1 ^= t2;
        x2 ^= t3;
        x3 ^= t4;
        x4 ^= t0;
        x1 ^= x0;
        x0 ^= x4;
        x3 ^= x2;
        x2 = ~x2;
        x0 ^= ror64(x0, 19) ^ ror64(x0, 28);
        x1 ^= ror64(x1, 61) ^ ror64(x1, 39);
        x2 ^= ror64(x2, 1) ^ ror64(x2, 6);
        x3 ^= ror64(x3, 10) ^ ror64(x3, 17);
        x4 ^= ror64(x4, 7) ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Combinational chain of UNROLL round slots; slots past R pass through.
    state_t w_slot [UNROLL+1];
    assign w_slot[0] = r_state;

    for (genvar j = 0; j < UNROLL; j++) begin : g_slot
        logic [4:0] w_idx;
        logic       w_en;
        logic [3:0] w_r;
        logic [7:0] w_rc;
        assign w_idx = {1'b0, r_cnt} + 5'(j);
        assign w_en  = w_idx < {1'b0, r_rounds};
        // constant index for p^R starts at 12-R
        assign w_r   = 4'd12 - r_rounds + r_cnt + 4'(j);
        assign w_rc  = {4'd15 - w_r, w_r};
        assign w_slot[j+1] = w_en ? ascon_round(w_slot[j], w_rc)
                                  : w_slot[j];
    end

    logic [3:0] w_left;
    logic [3:0] w_step;
    logic [3:0] w_cnt_nxt;
    logic       w_legal;

    assign w_left    = r_rounds - r_cnt;
    assign w_step    = (w_left > 4'(UNROLL)) ? 4'(UNROLL) : w_left;
    assign w_cnt_nxt = r_cnt + w_step;
    assign w_legal   = (rounds_i != 4'd0) && (rounds_i <= 4'd12);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_fsm_nxt = w_legal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_fsm_nxt = S_IDLE;
                end else if (w_cnt_nxt == r_rounds) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (abort_i || out_ready_i) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= '0;
            r_cnt    <= '0;
            r_rounds <= '0;
            r_err    <= 1'b0;
        end else if (r_fsm == S_IDLE && in_valid_i) begin
            r_state  <= state_i;
            r_cnt    <= '0;
            r_rounds <= rounds_i;
            r_err    <= !w_legal;
        end else if (r_fsm == S_RUN && !abort_i) begin
            r_state  <= w_slot[UNROLL];
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign in_ready_o  = (r_fsm == S_IDLE);
    assign out_valid_o = (r_fsm == S_DONE);
    assign busy_o      = (r_fsm == S_RUN) || (r_fsm == S_DONE);
    assign err_o       = r_err && (r_fsm == S_DONE);
    assign state_o     = r_state;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: UNROLL=1 and UNROLL=4 instances
// driven with directed and random requests against an array-based model.
module tb_ascon_permutation_engine;
    import ascon_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] abort;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [1:0] busy;
    logic [1:0] err;
    logic [3:0] rounds [2];
    state_t     st_in  [2];
    state_t     st_out [2];

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ascon_permutation_engine #(.UNROLL(1)) u_dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid[0]),
        .in_ready_o (in_ready[0]),
        .rounds_i   (rounds[0]),
        .state_i    (st_in[0]),
        .abort_i    (abort[0]),
        .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]),
        .state_o    (st_out[0]),
        .busy_o     (busy[0]),
        .err_o      (err[0])
    );

    ascon_permutation_engine #(.UNROLL(4)) u_dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid[1]),
        .in_ready_o (in_ready[1]),
        .rounds_i   (rounds[1]),
        .state_i    (st_in[1]),
        .abort_i    (abort[1]),
        .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]),
        .state_o    (st_out[1]),
        .busy_o     (busy[1]),
        .err_o      (err[1])
    );

    task automatic chk(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(logic [63:0] v, int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic state_t model(state_t s, int r);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        int c;
        if (r < 1 || r > 12) return s;
        for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
        for (int i = 0; i < r; i++) begin
            c = 12 - r + i;
            x[2][7:0] = x[2][7:0] ^ 8'((15 - c) * 16 + c);
            x[0] ^= x[4];
            x[4] ^= x[3];
            x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k+1)%5];
            for (int k = 0; k < 5; k++) x[k] ^= t[(k+1)%5];
            x[1] ^= x[0];
            x[0] ^= x[4];
            x[3] ^= x[2];
            x[2] = ~x[2];
            for (int k = 0; k < 5; k++)
                x[k] ^= ror(x[k], ra[k]) ^ ror(x[k], rb[k]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int lat_of(int d, int r);
        int u;
        u = (d == 0) ? 1 : 4;
        if (r < 1 || r > 12) return 0;
        return (r + u - 1) / u;
    endfunction

    function automatic state_t rnd_state();
        state_t s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic present(input int d, input int r, input state_t s);
        in_valid[d] = 1'b1;
        rounds[d]   = 4'(r);
        st_in[d]    = s;
    endtask

    // Called at the negedge right after the accepting posedge.
    task automatic wait_done(input int d, input int r, input state_t s);
        int n;
        int low;
        n = 0;
        low = 0;
        in_valid[d] = 1'b0;
        chk($sformatf("busy d%0d R%0d", d, r), 320'(busy[d]), 320'(1));
        while (!out_valid[d] && n < 40) begin
            if (!in_ready[d]) low++;
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) low++;
        chk($sformatf("lat d%0d R%0d", d, r), 320'(n),
            320'(lat_of(d, r)));
        chk($sformatf("rdy_low d%0d R%0d", d, r), 320'(low),
            320'(lat_of(d, r) + 1));
        chk($sformatf("state d%0d R%0d", d, r), st_out[d], model(s, r));
        chk($sformatf("err d%0d R%0d", d, r), 320'(err[d]),
            320'(r < 1 || r > 12));
    endtask

    task automatic retire(input int d);
        out_ready[d] = 1'b1;
        @(negedge clk);
        chk($sformatf("retire_rdy d%0d", d), 320'(in_ready[d]), 320'(1));
        chk($sformatf("retire_ov d%0d", d), 320'(out_valid[d]), 320'(0));
    endtask

    task automatic do_req(input int d, input int r, input state_t s);
        present(d, r, s);
        chk($sformatf("acc_rdy d%0d", d), 320'(in_ready[d]), 320'(1));
        @(negedge clk);
        wait_done(d, r, s);
        retire(d);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("rst_rdy d%0d", d), 320'(in_ready[d]), 320'(1));
        chk($sformatf("rst_ov d%0d", d), 320'(out_valid[d]), 320'(0));
        chk($sformatf("rst_busy d%0d", d), 320'(busy[d]), 320'(0));
        chk($sformatf("rst_err d%0d", d), 320'(err[d]), 320'(0));
        chk($sformatf("rst_state d%0d", d), st_out[d], 320'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t sa;
        state_t sb;
        state_t held;
        int     pulses;
        int     d;
        int     r;
        n_chk = 0;
        n_fail = 0;
        in_valid  = '0;
        abort     = '0;
        out_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            rounds[i] = '0;
            st_in[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        do_req(0, 12, '0);
        do_req(0, 1, '0);

        for (int i = 0; i < 3; i++) begin
            r  = (i == 0) ? 6 : (i == 1) ? 8 : 12;
            sa = rnd_state();
            do_req(1, r, sa);
            do_req(0, r, sa);
        end

        for (int dd = 0; dd < 2; dd++) begin
            sa = rnd_state();
            do_req(dd, 0, sa);
            do_req(dd, 13, sa);
            do_req(dd, 12, sa);
        end

        // backpressure in DONE, then retire and accept back-to-back
        sa = rnd_state();
        sb = rnd_state();
        out_ready[0] = 1'b0;
        present(0, 8, sa);
        @(negedge clk);
        wait_done(0, 8, sa);
        held = model(sa, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_state", st_out[0], held);
            chk("hold_rdy", 320'(in_ready[0]), 320'(0));
            chk("hold_ov", 320'(out_valid[0]), 320'(1));
        end
        present(0, 5, sb);
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("b2b_rdy", 320'(in_ready[0]), 320'(1));
        chk("b2b_ov", 320'(out_valid[0]), 320'(0));
        @(negedge clk);
        wait_done(0, 5, sb);
        retire(0);

        // abort in RUN cycle 3 of p^12
        sa = rnd_state();
        present(0, 12, sa);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_ov", 320'(out_valid[0]), 320'(0));
        chk("abort_rdy", 320'(in_ready[0]), 320'(1));
        chk("abort_busy", 320'(busy[0]), 320'(0));
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid[0]) pulses++;
        end
        chk("abort_pulses", 320'(pulses), 320'(0));

        // abort is ignored in IDLE; the request is still accepted
        sb = rnd_state();
        present(0, 3, sb);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        wait_done(0, 3, sb);
        retire(0);

        for (int i = 0; i < 24; i++) begin
            d  = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 15));
            sa = rnd_state();
            do_req(d, r, sa);
        end

        // reset while a result waits in DONE
        sa = rnd_state();
        out_ready[0] = 1'b0;
        present(0, 2, sa);
        @(negedge clk);
        wait_done(0, 2, sa);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset(0);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk_reset(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
